deskew: RTL and testbench

- Inverse of the skew stage. Takes a diagonally staggered Scalar stream, where lane i arrives i cycles after lane 0, and re-aligns it into one parallel vector with a single valid.
- Sits on the systolic-array boundary, wherever a staggered stream has to go back to parallel form: edge-row/column result drain, or loopback checking against the skew stage.
- Also flags misaligned input and counts the vectors it emits.

---
 rtl/deskew_pkg.sv | 12 +
 rtl/deskew_lane_delay.sv | 45 ++++
 rtl/deskew.sv | 71 +++++++
 tb/tb_deskew.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/deskew_pkg.sv
// Shared types for the deskew stage: scalar lane payload and default array sizing.
package deskew_pkg;

  localparam int unsigned SYS_ARRAY_LEN = 4;
  localparam int unsigned NUMBER_W      = 32;

  typedef struct packed {
    logic [NUMBER_W-1:0] data;
    logic                valid;
  } scalar_t;

endpackage

// File: rtl/deskew_lane_delay.sv
// Fixed-depth shift register of scalar_t; DEPTH=0 is a plain wire.
module deskew_lane_delay
  import deskew_pkg::*;
#(
  parameter int unsigned DEPTH  = 0,
  parameter int unsigned DATA_W = NUMBER_W
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    clear,
  input  scalar_t scalar_in,
  output scalar_t scalar_out
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_pass;
      assign unused_pass = ^{clk, rst, clear};
      assign scalar_out  = scalar_in;
    end else begin : g_shift
      logic [DEPTH-1:0][DATA_W-1:0] data_q;
      logic [DEPTH-1:0]             valid_q;

      // Clear drops every in-flight element including this cycle's input.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data_q  <= '0;
          valid_q <= '0;
        end else if (clear) begin
          valid_q <= '0;
        end else begin
          data_q[0]  <= DATA_W'(scalar_in.data);
          valid_q[0] <= scalar_in.valid;
          for (int i = 1; i < int'(DEPTH); i++) begin
            data_q[i]  <= data_q[i-1];
            valid_q[i] <= valid_q[i-1];
          end
        end
      end

      assign scalar_out = {NUMBER_W'(data_q[DEPTH-1]), valid_q[DEPTH-1]};
    end
  endgenerate

endmodule

// File: rtl/deskew.sv
// Re-aligns a diagonally skewed scalar stream into one parallel vector with a single valid.
module deskew
  import deskew_pkg::*;
#(
  parameter int unsigned LEN    = SYS_ARRAY_LEN,
  parameter int unsigned DATA_W = NUMBER_W,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  scalar_t [LEN-1:0]          scalar_in,
  input  logic                       clear,
  output logic [LEN-1:0][DATA_W-1:0] data_out,
  output logic                       data_valid,
  output logic                       align_err,
  output logic [CNT_W-1:0]           vec_count
);

  scalar_t [LEN-1:0]          delayed;
  logic    [LEN-1:0]          m;
  logic    [LEN-1:0][DATA_W-1:0] m_data;
  logic                       all_valid;
  logic                       mixed;

  // Lane i waits LEN-1-i cycles so all lanes of one vector meet at the output register.
  generate
    for (genvar gi = 0; gi < int'(LEN); gi++) begin : g_lane
      deskew_lane_delay #(
        .DEPTH  (LEN - 1 - gi),
        .DATA_W (DATA_W)
      ) u_lane (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .scalar_in  (scalar_in[gi]),
        .scalar_out (delayed[gi])
      );
      assign m[gi]      = delayed[gi].valid;
      assign m_data[gi] = DATA_W'(delayed[gi].data);
    end
  endgenerate

  always_comb begin
    all_valid = &m;
    mixed     = (|m) && !all_valid;
  end

  // Output register: only complete vectors load data_out and bump the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      align_err  <= 1'b0;
      vec_count  <= '0;
    end else if (clear) begin
      data_valid <= 1'b0;
      align_err  <= 1'b0;
      vec_count  <= '0;
    end else begin
      data_valid <= all_valid;
      if (all_valid) begin
        data_out  <= m_data;
        vec_count <= vec_count + CNT_W'(1);
      end
      if (mixed) begin
        align_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_deskew.sv
// Directed self-checking bench for deskew (LEN=4 main, CNT_W=2 wrap, LEN=1 degenerate).
module tb_deskew;
  import deskew_pkg::*;

  localparam int unsigned LEN = 4;

  logic clk = 1'b0;
  logic rst;
  logic clear;
  logic w_hold;
  logic w_rst;

  always #5 clk = ~clk;
  assign w_rst = rst | w_hold;

  scalar_t [LEN-1:0]        sin;
  logic    [LEN-1:0][31:0]  dout;
  logic                     dv;
  logic                     err;
  logic    [15:0]           cnt;

  logic    [LEN-1:0][31:0]  w_dout;
  logic                     w_dv;
  logic                     w_err;
  logic    [1:0]            w_cnt;

  scalar_t [0:0]            s1;
  logic    [0:0][31:0]      d1_out;
  logic                     d1_dv;
  logic                     d1_err;
  logic    [15:0]           d1_cnt;

  deskew #(.LEN(LEN), .DATA_W(32), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .scalar_in(sin), .clear(clear),
    .data_out(dout), .data_valid(dv), .align_err(err), .vec_count(cnt)
  );

  deskew #(.LEN(LEN), .DATA_W(32), .CNT_W(2)) u_wrap (
    .clk(clk), .rst(w_rst), .scalar_in(sin), .clear(clear),
    .data_out(w_dout), .data_valid(w_dv), .align_err(w_err), .vec_count(w_cnt)
  );

  deskew #(.LEN(1), .DATA_W(32), .CNT_W(16)) u_one (
    .clk(clk), .rst(rst), .scalar_in(s1), .clear(clear),
    .data_out(d1_out), .data_valid(d1_dv), .align_err(d1_err), .vec_count(d1_cnt)
  );

  // 1.0 .. 7.0 as IEEE-754 single bits
  logic [31:0] fv [1:7] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                            32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000};

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Invalid lanes carry junk data that must never reach data_out.
  task automatic idle();
    for (int i = 0; i < int'(LEN); i++)
      sin[i] = '{data: 32'hDEAD_0000 + 32'(i), valid: 1'b0};
  endtask

  task automatic set_lane(input int i, input logic [31:0] v);
    sin[i] = '{data: v, valid: 1'b1};
  endtask

  task automatic send_one(input logic [31:0] v, input logic [15:0] exp_cnt,
                          input logic exp_err, input string tag);
    for (int c = 0; c < int'(LEN); c++) begin
      idle();
      set_lane(c, v);
      step();
      if (c < int'(LEN) - 1) chk({tag, "_early_dv"}, 128'(dv), 128'(0));
    end
    chk({tag, "_dv"}, 128'(dv), 128'(1));
    chk({tag, "_data"}, 128'(dout), {4{v}});
    chk({tag, "_cnt"}, 128'(cnt), 128'(exp_cnt));
    chk({tag, "_err"}, 128'(err), 128'(exp_err));
    idle();
    step();
    chk({tag, "_dv_drop"}, 128'(dv), 128'(0));
    chk({tag, "_data_hold"}, 128'(dout), {4{v}});
    for (int k = 0; k < 3; k++) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] e;
    int k;

    rst    = 1'b1;
    clear  = 1'b0;
    w_hold = 1'b1;
    idle();
    s1[0] = '{data: 32'h1234_5678, valid: 1'b0};
    #12;
    chk("rst_dv",   128'(dv),   128'(0));
    chk("rst_err",  128'(err),  128'(0));
    chk("rst_cnt",  128'(cnt),  128'(0));
    chk("rst_data", 128'(dout), 128'(0));
    chk("rst_d1",   128'(d1_dv), 128'(0));
    rst = 1'b0;

    send_one(32'h40A0_0000, 16'd1, 1'b0, "single");

    // Loopback of a skewed stream: four back-to-back vectors {1,2,3,4}+k.
    for (int c = 0; c < 7; c++) begin
      idle();
      for (int i = 0; i < int'(LEN); i++) begin
        k = c - i;
        if (k >= 0 && k < 4) set_lane(i, fv[i + 1 + k]);
      end
      step();
      if (c >= 3) begin
        for (int i = 0; i < int'(LEN); i++) e[i*32 +: 32] = fv[i + 1 + (c - 3)];
        chk("loop_dv",   128'(dv),   128'(1));
        chk("loop_data", 128'(dout), e);
        chk("loop_cnt",  128'(cnt),  128'(c - 1));
      end else begin
        chk("loop_early_dv", 128'(dv), 128'(0));
      end
    end
    idle();
    step();
    chk("loop_dv_drop", 128'(dv), 128'(0));
    chk("loop_err", 128'(err), 128'(0));
    for (int j = 0; j < 3; j++) step();

    // Lane 2 arrives one cycle late.
    idle(); set_lane(0, 32'h40C0_0000); step();
    idle(); set_lane(1, 32'h40C0_0000); step();
    idle(); step();
    idle(); set_lane(2, 32'h40C0_0000); set_lane(3, 32'h40C0_0000); step();
    chk("mis_err", 128'(err), 128'(1));
    chk("mis_dv",  128'(dv),  128'(0));
    idle();
    for (int j = 0; j < 4; j++) begin
      step();
      chk("mis_dv_tail", 128'(dv), 128'(0));
    end
    chk("mis_cnt", 128'(cnt), 128'(5));
    send_one(32'h40C0_0000, 16'd6, 1'b1, "sticky");

    // Clear with lanes 0-1 in flight; lane 2 presented during clear is dropped.
    idle(); set_lane(0, 32'h40E0_0000); step();
    idle(); set_lane(1, 32'h40E0_0000); step();
    idle(); set_lane(2, 32'h40E0_0000); clear = 1'b1; step();
    clear = 1'b0;
    idle();
    chk("clr_cnt", 128'(cnt), 128'(0));
    chk("clr_err", 128'(err), 128'(0));
    chk("clr_dv",  128'(dv),  128'(0));
    for (int j = 0; j < 4; j++) begin
      step();
      chk("clr_dv_after",  128'(dv),  128'(0));
      chk("clr_err_after", 128'(err), 128'(0));
    end
    send_one(32'h3F80_0000, 16'd1, 1'b0, "post_clear");

    // Async reset between edges with two vectors in flight.
    idle(); set_lane(0, 32'h4000_0000); step();
    idle(); set_lane(1, 32'h4000_0000); set_lane(0, 32'h4040_0000); step();
    chk("pre_rst_cnt", 128'(cnt), 128'(1));
    idle();
    #3;
    rst = 1'b1;
    #1;
    chk("arst_data", 128'(dout), 128'(0));
    chk("arst_cnt",  128'(cnt),  128'(0));
    chk("arst_dv",   128'(dv),   128'(0));
    #1;
    rst = 1'b0;
    for (int j = 0; j < 4; j++) begin
      step();
      chk("arst_err_after", 128'(err), 128'(0));
      chk("arst_dv_after",  128'(dv),  128'(0));
    end
    send_one(32'h4040_0000, 16'd1, 1'b0, "post_rst");

    // Counter wrap on the CNT_W=2 instance: five back-to-back vectors.
    w_hold = 1'b0;
    for (int c = 0; c < 8; c++) begin
      idle();
      for (int i = 0; i < int'(LEN); i++) begin
        k = c - i;
        if (k >= 0 && k < 5) set_lane(i, 32'h4080_0000);
      end
      step();
      if (c >= 3) begin
        chk("wrap_dv",  128'(w_dv),  128'(1));
        chk("wrap_cnt", 128'(w_cnt), 128'((c - 2) % 4));
      end else begin
        chk("wrap_cnt_early", 128'(w_cnt), 128'(0));
      end
    end
    idle();
    step();
    chk("wrap_dv_drop", 128'(w_dv), 128'(0));

    // LEN=1 degenerates to a single register.
    s1[0] = '{data: 32'h3F80_0000, valid: 1'b1};
    #1;
    chk("len1_pre_dv", 128'(d1_dv), 128'(0));
    step();
    chk("len1_dv",   128'(d1_dv),  128'(1));
    chk("len1_data", 128'(d1_out), 128'(32'h3F80_0000));
    chk("len1_cnt",  128'(d1_cnt), 128'(1));
    s1[0] = '{data: 32'hDEAD_BEEF, valid: 1'b0};
    step();
    chk("len1_dv_drop", 128'(d1_dv),  128'(0));
    chk("len1_hold",    128'(d1_out), 128'(32'h3F80_0000));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
